mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-stage consumer of the X/M pipeline register outputs (m_ctrl, m_data, mw_ctrl); the reader side of that interface.
- Runs loads and stores over a req/ack data-memory port, stalling the pipeline until ack.
- Handles byte-lane steering and sign extension.
- Registers the M/W boundary: writeback value, destination, MW control.

Parameters:
- DATA_W, 32, data and address width; only 32 is supported.
- TIMEOUT_CYCLES, 64, REQ-state cycle limit before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- m_ctrl  in  M_ctrl  mem_read, mem_write, size (SZ_BYTE/SZ_HALF/SZ_WORD), sign
- m_data  in  M_data  dst, addr (ALU result), val (store data)
- mw_ctrl_in  in  MW_ctrl  writeback control from the X/M register; includes reg_write
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address, low 2 bits forced to 0
- dmem_be  out  4  byte enables for stores
- dmem_wdata  out  32  store data, replicated across lanes
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  load data; valid when dmem_ack=1
- stall  out  1  holds upstream stages and the X/M register
- m_fwd  out  32  combinational M-stage forwarding value, equal to m_data.addr
- w_data  out  W_data  registered: dst, val
- mw_ctrl_out  out  MW_ctrl  registered writeback control
- misalign_exc  out  1  registered one-cycle pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; dmem_req, dmem_we, dmem_be, misalign_exc = 0.
  - w_data = 0; mw_ctrl_out = all-zero (bubble).
- Operation decode:
  - mem_op = mem_read | mem_write.
  - If mem_read and mem_write are both 1, the access is treated as a store.
- Misalignment:
  - SZ_HALF with addr[0]=1, or SZ_WORD with addr[1:0]≠0.
  - No request is issued.
  - Next edge: misalign_exc=1 for one cycle, mw_ctrl_out = bubble.
- FSM states: IDLE, REQ.
- IDLE, no mem_op (or misaligned):
  - stall=0.
  - Next edge: w_data.dst = m_data.dst, w_data.val = m_data.addr, mw_ctrl_out = mw_ctrl_in (bubble if misaligned).
  - Latency 1 cycle.
- IDLE, aligned mem_op:
  - stall=1.
  - Next edge: enter REQ; latch addr, we, be, wdata, size, sign, dst and mw_ctrl_in; mw_ctrl_out = bubble.
- REQ:
  - dmem_req=1; all dmem outputs stay stable until ack.
  - stall = ~dmem_ack.
  - On ack edge: return to IDLE; mw_ctrl_out = latched ctrl; w_data.dst = latched dst.
  - Load: w_data.val = extended load data. Store: w_data.val = latched addr.
  - Minimum memory-op latency is 2 cycles (1 forced stall cycle).
- Store lanes, little-endian, o = addr[1:0]:
  - SZ_BYTE: be = 1<<o; wdata = {4{val[7:0]}}.
  - SZ_HALF: be = o[1] ? 4'b1100 : 4'b0011; wdata = {2{val[15:0]}}.
  - SZ_WORD: be = 4'b1111; wdata = val.
- Loads:
  - dmem_be=0.
  - Data = dmem_rdata >> (8*o), truncated to size.
  - Sign-extended if sign=1, else zero-extended.
- Stalled cycles always emit a bubble on mw_ctrl_out; no duplicate writeback is possible.
- dmem_ack while in IDLE is ignored, including a stale ack after a reset mid-REQ.
- Reset during REQ drops dmem_req immediately (asynchronous); the in-flight instruction is discarded.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on REQ entry and increments each REQ cycle without ack.
  - At TIMEOUT_CYCLES: abort to IDLE; mw_ctrl_out = bubble; misalign_exc stays 0.
  - Registered 1-cycle output bus_err=1 (port present only with the macro).
  - An ack in the same cycle as expiry wins; no error is raised.
- Undefined: REQ waits indefinitely; no bus_err port; no counter logic.

Decomposition:
- Shared definitions package gets:
  - Size enum (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2).
  - M_ctrl fields mem_read, mem_write, size, sign.
  - W_data struct {dst, val}.
  - MW_BUBBLE constant (all-zero MW_ctrl).
  - MemState enum {IDLE, REQ}.
- One combinational sub-module, mem_lane_align: store be/wdata generation and load extract/extend.
- FSM, timeout counter and M/W registers remain in mem_access.

Test Plan:
- ALU op, addr=0x0000_1234, dst=5, reg_write=1, no mem -> next cycle w_data={5, 0x1234}, reg_write=1, stall never high.
- SZ_BYTE signed load at 0x103, rdata=0x80FF_0000, ack on first REQ cycle -> stall high 1 cycle; w_data.val=0xFFFF_FF80; dmem_addr=0x100.
- SZ_HALF store at 0x202, val=0x0000_BEEF, ack after 3 REQ cycles -> be=4'b1100, wdata=0xBEEF_BEEF held stable; stall high 4 cycles; bubbles during stall.
- SZ_WORD load at 0x302 -> no dmem_req; misalign_exc pulses once; mw_ctrl_out=bubble; stall=0.
- Drive rst low mid-REQ, then send a stray ack after reset -> dmem_req low immediately; outputs stay at reset values; ack ignored.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, never ack -> bus_err pulses after 4 REQ cycles; state=IDLE; stall drops.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage: access control, pipeline register
// payloads, the M/W bubble constant and the access FSM state encoding.
package mem_access_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } MemSize;

   typedef struct packed {
      logic   mem_read;
      logic   mem_write;
      MemSize size;
      logic   sign;
   } M_ctrl;

   typedef struct packed {
      logic [REG_W-1:0]  dst;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] val;
   } M_data;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } MW_ctrl;

   typedef struct packed {
      logic [REG_W-1:0]  dst;
      logic [DATA_W-1:0] val;
   } W_data;

   localparam MW_ctrl MW_BUBBLE = '0;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } MemState;

   // Half accesses need an even address, word accesses a 4-byte aligned one.
   function automatic logic is_misaligned(input MemSize size, input logic [1:0] offset);
      return ((size == SZ_HALF) && offset[0]) ||
             ((size == SZ_WORD) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// Byte-lane steering for the memory stage: builds store byte enables and
// replicated store data, and extracts/extends load data from a 32-bit word.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  MemSize      size,
   input  logic        sign,
   input  logic [1:0]  offset,
   input  logic [31:0] store_val,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_val
);

   logic [31:0] shifted;

   // Store side: enable only the addressed lanes, replicate data into every lane.
   always_comb begin
      be    = 4'b1111;
      wdata = store_val;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << offset;
            wdata = {4{store_val[7:0]}};
         end
         SZ_HALF: begin
            be    = offset[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_val[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = store_val;
         end
      endcase
   end

   // Load side: move the addressed lane down to bit 0, then trim and extend.
   always_comb begin
      shifted  = rdata >> {offset, 3'b000};
      load_val = shifted;
      case (size)
         SZ_BYTE: load_val = {{24{sign & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_val = {{16{sign & shifted[15]}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage: issues loads/stores on a req/ack data port, stalls
// the upstream pipe until the access completes, and registers the M/W
// boundary. Optional macro MEM_TIMEOUT_EN adds a REQ-cycle watchdog that
// aborts a hung access and reports it on bus_err.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  M_ctrl             m_ctrl,
   input  M_data             m_data,
   input  MW_ctrl            mw_ctrl_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall,
   output logic [DATA_W-1:0] m_fwd,
   output W_data             w_data,
   output MW_ctrl            mw_ctrl_out,
`ifdef MEM_TIMEOUT_EN
   output logic              bus_err,
`endif
   output logic              misalign_exc
);

   MemState     state_q, state_d;
   logic        mem_op, misaligned, start_access, timeout_hit;

   logic [31:0] addr_q, wdata_q;
   logic        we_q, sign_q;
   logic [3:0]  be_q;
   MemSize      size_q;
   logic [4:0]  dst_q;
   MW_ctrl      ctrl_q;

   MemSize      lane_size;
   logic        lane_sign;
   logic [1:0]  lane_off;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, lane_load;

   // Decode the incoming operation and decide whether a bus access starts now.
   always_comb begin
      mem_op       = m_ctrl.mem_read | m_ctrl.mem_write;
      misaligned   = mem_op & is_misaligned(m_ctrl.size, m_data.addr[1:0]);
      start_access = (state_q == IDLE) & mem_op & ~misaligned;
   end

   // The lane unit sees the live instruction in IDLE and the latched one in REQ.
   always_comb begin
      lane_size = (state_q == REQ) ? size_q : m_ctrl.size;
      lane_sign = (state_q == REQ) ? sign_q : m_ctrl.sign;
      lane_off  = (state_q == REQ) ? addr_q[1:0] : m_data.addr[1:0];
   end

   mem_lane_align u_lane (
      .size      (lane_size),
      .sign      (lane_sign),
      .offset    (lane_off),
      .store_val (m_data.val),
      .rdata     (dmem_rdata),
      .be        (lane_be),
      .wdata     (lane_wdata),
      .load_val  (lane_load)
   );

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_cnt;

   // Watchdog: counts unanswered REQ cycles; an ack in the expiry cycle wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= timeout_hit;
         if (start_access)
            tmo_cnt <= '0;
         else if ((state_q == REQ) && !dmem_ack)
            tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

   assign timeout_hit = (state_q == REQ) & ~dmem_ack & (tmo_cnt == TIMEOUT_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // State register for the access FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state and stall: hold upstream from access start until ack or abort.
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_access) begin
               state_d = REQ;
               stall   = 1'b1;
            end
         end
         REQ: begin
            if (dmem_ack) begin
               state_d = IDLE;
            end else if (timeout_hit) begin
               state_d = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // M/W boundary and latched access: every stalled cycle emits a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         be_q         <= '0;
         size_q       <= SZ_BYTE;
         sign_q       <= 1'b0;
         dst_q        <= '0;
         ctrl_q       <= MW_BUBBLE;
         w_data       <= '0;
         mw_ctrl_out  <= MW_BUBBLE;
         misalign_exc <= 1'b0;
      end else begin
         misalign_exc <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_access) begin
                  addr_q      <= m_data.addr;
                  we_q        <= m_ctrl.mem_write;
                  be_q        <= m_ctrl.mem_write ? lane_be : 4'b0000;
                  wdata_q     <= lane_wdata;
                  size_q      <= m_ctrl.size;
                  sign_q      <= m_ctrl.sign;
                  dst_q       <= m_data.dst;
                  ctrl_q      <= mw_ctrl_in;
                  mw_ctrl_out <= MW_BUBBLE;
               end else begin
                  w_data.dst   <= m_data.dst;
                  w_data.val   <= m_data.addr;
                  mw_ctrl_out  <= misaligned ? MW_BUBBLE : mw_ctrl_in;
                  misalign_exc <= misaligned;
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  mw_ctrl_out <= ctrl_q;
                  w_data.dst  <= dst_q;
                  w_data.val  <= we_q ? addr_q : lane_load;
               end else begin
                  mw_ctrl_out <= MW_BUBBLE;
               end
            end
            default: mw_ctrl_out <= MW_BUBBLE;
         endcase
      end
   end

   assign dmem_req   = (state_q == REQ);
   assign dmem_we    = we_q;
   assign dmem_addr  = {addr_q[31:2], 2'b00};
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;
   assign m_fwd      = m_data.addr;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: ALU pass-through, signed byte
// load, stalled half store, misaligned word load, reset mid-access, and the
// watchdog abort when MEM_TIMEOUT_EN is defined.
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   M_ctrl       m_ctrl;
   M_data       m_data;
   MW_ctrl      mw_ctrl_in;
   logic        dmem_req, dmem_we, dmem_ack, stall, misalign_exc;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, m_fwd;
   logic [3:0]  dmem_be;
   W_data       w_data;
   MW_ctrl      mw_ctrl_out;
`ifdef MEM_TIMEOUT_EN
   logic        bus_err;
`endif

   int compared   = 0;
   int mismatched = 0;

   mem_access #(.DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .m_ctrl       (m_ctrl),
      .m_data       (m_data),
      .mw_ctrl_in   (mw_ctrl_in),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_ack     (dmem_ack),
      .dmem_rdata   (dmem_rdata),
      .stall        (stall),
      .m_fwd        (m_fwd),
      .w_data       (w_data),
      .mw_ctrl_out  (mw_ctrl_out),
`ifdef MEM_TIMEOUT_EN
      .bus_err      (bus_err),
`endif
      .misalign_exc (misalign_exc)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic applyStimulus(input M_ctrl c, input M_data d, input MW_ctrl w);
      m_ctrl     = c;
      m_data     = d;
      mw_ctrl_in = w;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Directed sequence: inputs change just after a falling edge, outputs are checked there too.
   initial begin
      rst        = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      applyStimulus('0, '0, '0);
      repeat (2) @(negedge clk);

      checkOutput("rst_req",      64'(dmem_req),     64'd0);
      checkOutput("rst_we",       64'(dmem_we),      64'd0);
      checkOutput("rst_be",       64'(dmem_be),      64'd0);
      checkOutput("rst_misalign", 64'(misalign_exc), 64'd0);
      checkOutput("rst_wdata",    64'(w_data),       64'd0);
      checkOutput("rst_mwctrl",   64'(mw_ctrl_out),  64'd0);
`ifdef MEM_TIMEOUT_EN
      checkOutput("rst_buserr",   64'(bus_err),      64'd0);
`endif
      rst = 1'b1;

      // ALU result passes straight through in one cycle
      applyStimulus('0, '{dst: 5'd5, addr: 32'h0000_1234, val: 32'h0}, '{reg_write: 1'b1, mem_to_reg: 1'b0});
      #1;
      checkOutput("alu_stall0", 64'(stall), 64'd0);
      checkOutput("alu_fwd",    64'(m_fwd), 64'h1234);
      @(negedge clk);
      checkOutput("alu_wdata",  64'(w_data),      {27'd0, 5'd5, 32'h0000_1234});
      checkOutput("alu_mwctrl", 64'(mw_ctrl_out), 64'b10);
      checkOutput("alu_stall1", 64'(stall),       64'd0);

      // Signed byte load at 0x103, acked on the first REQ cycle
      applyStimulus('{mem_read: 1'b1, mem_write: 1'b0, size: SZ_BYTE, sign: 1'b1},
                    '{dst: 5'd7, addr: 32'h0000_0103, val: 32'h0}, '{reg_write: 1'b1, mem_to_reg: 1'b1});
      #1;
      checkOutput("lb_stall_idle", 64'(stall),    64'd1);
      checkOutput("lb_noreq_idle", 64'(dmem_req), 64'd0);
      @(negedge clk);
      checkOutput("lb_req",    64'(dmem_req),    64'd1);
      checkOutput("lb_addr",   64'(dmem_addr),   64'h100);
      checkOutput("lb_we",     64'(dmem_we),     64'd0);
      checkOutput("lb_be",     64'(dmem_be),     64'd0);
      checkOutput("lb_bubble", 64'(mw_ctrl_out), 64'd0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h80FF_0000;
      #1;
      checkOutput("lb_stall_ack", 64'(stall), 64'd0);
      @(negedge clk);
      dmem_ack = 1'b0;
      checkOutput("lb_wdata",  64'(w_data),      {27'd0, 5'd7, 32'hFFFF_FF80});
      checkOutput("lb_mwctrl", 64'(mw_ctrl_out), 64'b11);
      checkOutput("lb_req_done", 64'(dmem_req),  64'd0);

      // Half store at 0x202, acked in the fourth REQ cycle
      applyStimulus('{mem_read: 1'b0, mem_write: 1'b1, size: SZ_HALF, sign: 1'b0},
                    '{dst: 5'd9, addr: 32'h0000_0202, val: 32'h0000_BEEF}, '{reg_write: 1'b1, mem_to_reg: 1'b0});
      #1;
      checkOutput("sh_stall_idle", 64'(stall), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("sh_req",    64'(dmem_req),    64'd1);
         checkOutput("sh_addr",   64'(dmem_addr),   64'h200);
         checkOutput("sh_we",     64'(dmem_we),     64'd1);
         checkOutput("sh_be",     64'(dmem_be),     64'hC);
         checkOutput("sh_data",   64'(dmem_wdata),  64'hBEEF_BEEF);
         checkOutput("sh_bubble", 64'(mw_ctrl_out), 64'd0);
         checkOutput("sh_stall",  64'(stall),       64'd1);
      end
      @(negedge clk);
      checkOutput("sh_be_last",   64'(dmem_be),    64'hC);
      checkOutput("sh_data_last", 64'(dmem_wdata), 64'hBEEF_BEEF);
      dmem_ack = 1'b1;
      #1;
      checkOutput("sh_stall_ack", 64'(stall), 64'd0);
      @(negedge clk);
      dmem_ack = 1'b0;
      checkOutput("sh_wdata",  64'(w_data),      {27'd0, 5'd9, 32'h0000_0202});
      checkOutput("sh_mwctrl", 64'(mw_ctrl_out), 64'b10);
      checkOutput("sh_req_done", 64'(dmem_req),  64'd0);

      // Misaligned word load at 0x302: no request, one-cycle exception
      applyStimulus('{mem_read: 1'b1, mem_write: 1'b0, size: SZ_WORD, sign: 1'b0},
                    '{dst: 5'd3, addr: 32'h0000_0302, val: 32'h0}, '{reg_write: 1'b1, mem_to_reg: 1'b1});
      #1;
      checkOutput("mis_stall", 64'(stall),    64'd0);
      checkOutput("mis_noreq", 64'(dmem_req), 64'd0);
      @(negedge clk);
      checkOutput("mis_exc",    64'(misalign_exc), 64'd1);
      checkOutput("mis_bubble", 64'(mw_ctrl_out),  64'd0);
      checkOutput("mis_noreq2", 64'(dmem_req),     64'd0);
      checkOutput("mis_wdata",  64'(w_data),       {27'd0, 5'd3, 32'h0000_0302});
      applyStimulus('0, '{dst: 5'd4, addr: 32'h0000_0044, val: 32'h0}, '{reg_write: 1'b1, mem_to_reg: 1'b0});
      @(negedge clk);
      checkOutput("mis_exc_clr", 64'(misalign_exc), 64'd0);
      checkOutput("post_mwctrl", 64'(mw_ctrl_out),  64'b10);
      checkOutput("post_wdata",  64'(w_data),       {27'd0, 5'd4, 32'h0000_0044});

      // Reset in the middle of a REQ, then a stale ack after reset
      applyStimulus('{mem_read: 1'b1, mem_write: 1'b0, size: SZ_WORD, sign: 1'b0},
                    '{dst: 5'd6, addr: 32'h0000_0400, val: 32'h0}, '{reg_write: 1'b1, mem_to_reg: 1'b1});
      @(negedge clk);
      checkOutput("rr_req", 64'(dmem_req), 64'd1);
      applyStimulus('0, '0, '0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rr_req_drop", 64'(dmem_req),    64'd0);
      checkOutput("rr_mwctrl",   64'(mw_ctrl_out), 64'd0);
      checkOutput("rr_wdata",    64'(w_data),      64'd0);
      checkOutput("rr_stall",    64'(stall),       64'd0);
      @(negedge clk);
      rst        = 1'b1;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      dmem_ack = 1'b0;
      checkOutput("stale_req",    64'(dmem_req),     64'd0);
      checkOutput("stale_wdata",  64'(w_data),       64'd0);
      checkOutput("stale_mwctrl", 64'(mw_ctrl_out),  64'd0);
      checkOutput("stale_exc",    64'(misalign_exc), 64'd0);

`ifdef MEM_TIMEOUT_EN
      // Never acked: abort after four REQ cycles with a one-cycle bus_err
      applyStimulus('{mem_read: 1'b1, mem_write: 1'b0, size: SZ_WORD, sign: 1'b0},
                    '{dst: 5'd2, addr: 32'h0000_0500, val: 32'h0}, '{reg_write: 1'b1, mem_to_reg: 1'b1});
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput("to_req",    64'(dmem_req), 64'd1);
         checkOutput("to_stall",  64'(stall),    64'd1);
         checkOutput("to_buserr", 64'(bus_err),  64'd0);
         @(negedge clk);
      end
      checkOutput("to_req_last",   64'(dmem_req), 64'd1);
      checkOutput("to_stall_drop", 64'(stall),    64'd0);
      applyStimulus('0, '0, '0);
      @(negedge clk);
      checkOutput("to_buserr_set", 64'(bus_err),      64'd1);
      checkOutput("to_req_off",    64'(dmem_req),     64'd0);
      checkOutput("to_bubble",     64'(mw_ctrl_out),  64'd0);
      checkOutput("to_exc",        64'(misalign_exc), 64'd0);
      @(negedge clk);
      checkOutput("to_buserr_clr", 64'(bus_err), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
